tristate_bus_arbiter17: RTL

Round-robin arbiter that shares one 17-bit tristate bus among `NREQ` requesters. It drives the `enable` input of each requester's `trstate17` buffer. The block guarantees at most one driver at any time and a dead (undriven) turnaround cycle between different owners. It sits beside the bank of `trstate17` instances on the shared bus and is the only source of their enables.

---
 rtl/bus17_pkg.sv | 20 ++
 rtl/tristate_bus_arbiter17_if.sv | 37 +++
 rtl/tristate_bus_arbiter17_rr_pick.sv | 34 +++
 rtl/tristate_bus_arbiter17.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bus17_pkg.sv
// ----------------------------------------------------------------------------
// bus17_pkg
// Shared definitions for the 17-bit tristate bus arbiter.
//   BUS_W       : width of the shared tristate data bus.
//   arb_state_t : arbiter bus-ownership state.
//                 IDLE  = nobody drives the bus
//                 DRIVE = exactly one enable is high
//                 TURN  = one dead cycle between owners
// ----------------------------------------------------------------------------
package bus17_pkg;

    localparam int BUS_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tristate_bus_arbiter17_if.sv
// ----------------------------------------------------------------------------
// tristate_bus_arbiter17_if
// Request/enable bundle between the arbiter and the requester bank.
//   req      : per-requester bus request, level-sensitive
//   enable   : one-hot or zero; bit i enables requester i's trstate17 buffer
//   owner    : index of the current driver, meaningful while bus_busy=1
//   bus_busy : high while some enable bit is set
// Modports:
//   master : arbiter side (samples req, drives enable/owner/bus_busy)
//   slave  : requester side (drives req, observes the grant)
// ----------------------------------------------------------------------------
interface tristate_bus_arbiter17_if #(
    parameter int NREQ = 4
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] enable;
    logic [IW-1:0]   owner;
    logic            bus_busy;

    modport master (
        input  req,
        output enable,
        output owner,
        output bus_busy
    );

    modport slave (
        output req,
        input  enable,
        input  owner,
        input  bus_busy
    );

endinterface

// File: rtl/tristate_bus_arbiter17_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker.
//   req   : request vector
//   last  : most recently granted index; the search starts at last+1
//   found : some request bit is set
//   idx   : first set request at or after last+1 (mod NREQ)
// The index in 'last' is visited last, so a previous owner is still eligible
// but only when no other requester is asking.
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk offsets 1..NREQ from 'last'; the first hit wins.
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IW'((int'(last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter17.sv
// ----------------------------------------------------------------------------
// tristate_bus_arbiter17
// Round-robin owner selection for one shared 17-bit tristate bus. Produces the
// enable of every requester's trstate17 buffer, guaranteeing at most one
// driver and at least one undriven turnaround cycle between any two grants
// (including a re-grant to the same requester).
//
// Parameters:
//   NREQ     : number of requesters, 2..8
//   MAX_HOLD : max consecutive DRIVE cycles while others wait (timeout build)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tristate_bus_arbiter17_if.master (req in; enable/owner/bus_busy out)
//
// Build option:
//   ARB_TIMEOUT_EN : when defined, a hold counter forces the owner off the bus
//                    after MAX_HOLD DRIVE cycles if another requester is
//                    waiting. When undefined, an owner keeps the bus until it
//                    drops req and MAX_HOLD only takes part in the range check.
//
// All outputs come straight from flops; req has no combinational path to them.
// ----------------------------------------------------------------------------
module tristate_bus_arbiter17
    import bus17_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tristate_bus_arbiter17_if.master    bus
);

    localparam int              IW  = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    // Elaboration-time parameter range check.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("tristate_bus_arbiter17: NREQ must be within 2..8");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("tristate_bus_arbiter17: MAX_HOLD must be at least 1");
    end

    arb_state_t      state_q,    state_d;
    logic [NREQ-1:0] enable_q,   enable_d;
    logic [IW-1:0]   owner_q,    owner_d;
    logic [IW-1:0]   last_q,     last_d;
    logic            bus_busy_q, bus_busy_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            preempt;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (bus.req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    // Counter width holds MAX_HOLD-1 even when MAX_HOLD=1.
    localparam int            HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          others_req;

    // Anyone other than the current owner asking for the bus.
    assign others_req = |(bus.req & ~(ONE << owner_q));
    assign preempt    = (state_q == DRIVE) && (hold_cnt_q == HOLD_LAST)
                        && others_req;

    // Held at zero outside DRIVE so the first DRIVE cycle sees 0; counts each
    // DRIVE cycle and sticks at MAX_HOLD-1 so a lone owner is never wrapped.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q != DRIVE) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // Next-state and registered-output logic. Leaving DRIVE always goes via
    // TURN with every enable low, so a release and a new grant can never land
    // on the same edge.
    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        owner_d    = owner_q;
        last_d     = last_q;
        bus_busy_d = bus_busy_q;

        case (state_q)
            IDLE, TURN: begin
                if (pick_found) begin
                    state_d    = DRIVE;
                    enable_d   = ONE << pick_idx;
                    owner_d    = pick_idx;
                    last_d     = pick_idx;
                    bus_busy_d = 1'b1;
                end else begin
                    state_d    = IDLE;
                    enable_d   = '0;
                    bus_busy_d = 1'b0;
                end
            end

            DRIVE: begin
                // Non-owner requests are not looked at here; they wait for
                // the pick made from TURN.
                if (!bus.req[owner_q] || preempt) begin
                    state_d    = TURN;
                    enable_d   = '0;
                    bus_busy_d = 1'b0;
                end
            end

            default: begin
                state_d    = IDLE;
                enable_d   = '0;
                bus_busy_d = 1'b0;
            end
        endcase
    end

    // Asynchronous reset drops every enable at once so the bus floats in the
    // same cycle. last resets to NREQ-1 so index 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            enable_q   <= '0;
            owner_q    <= '0;
            last_q     <= IW'(NREQ - 1);
            bus_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            bus_busy_q <= bus_busy_d;
        end
    end

    assign bus.enable   = enable_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = bus_busy_q;

endmodule
